// File: rtl/link_pkg.sv
// Shared definitions for the byte link bridge: mode encodings and state enum.
package link_pkg;

  // Bridge state; encodings match the 2-bit mode input one to one.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StRun  = 2'b10,
    StDump = 2'b11
  } link_state_e;

endpackage

// File: rtl/byte_serializer.sv
// Debug word serializer: snapshots a word and streams its bytes lane 0 first,
// re-snapshotting on the last lane so the stream has no gaps.
module byte_serializer #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [WORD_W-1:0] dbg_word,
  output logic [7:0]        out_byte,
  output logic              out_valid
);

  localparam int unsigned NB     = WORD_W / 8;
  localparam int unsigned LANE_W = $clog2(NB);

  logic [WORD_W-1:0] snap_q;
  logic [LANE_W-1:0] lane_q;
  logic              started_q;
  logic [LANE_W-1:0] lane_nxt;
  logic [7:0]        next_byte;
  logic              reload;

  // Next lane to present and whether this cycle takes a fresh snapshot.
  always_comb begin
    lane_nxt  = lane_q + LANE_W'(1);
    next_byte = snap_q[int'(lane_nxt) * 8 +: 8];
    reload    = !started_q || (lane_q == LANE_W'(NB - 1));
  end

  // Snapshot and lane stepping; leaving DUMP (en low) drops the stream at once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_q    <= '0;
      lane_q    <= '0;
      started_q <= 1'b0;
      out_byte  <= '0;
      out_valid <= 1'b0;
    end else if (!en) begin
      lane_q    <= '0;
      started_q <= 1'b0;
      out_byte  <= '0;
      out_valid <= 1'b0;
    end else if (reload) begin
      // Lane 0 comes straight from the live word, which is the value being captured.
      snap_q    <= dbg_word;
      lane_q    <= '0;
      started_q <= 1'b1;
      out_byte  <= dbg_word[7:0];
      out_valid <= 1'b1;
    end else begin
      lane_q    <= lane_nxt;
      out_byte  <= next_byte;
      out_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/byte_link_bridge.sv
// Byte link bridge: assembles loaded bytes into memory words, paces the CPU in
// RUN, and streams the CPU debug word out byte by byte in DUMP.
module byte_link_bridge import link_pkg::*; #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned CPU_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_step,
  input  logic [WORD_W-1:0] dbg_word,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  output logic              busy
);

  localparam int unsigned NB    = WORD_W / 8;
  localparam int unsigned IDX_W = $clog2(NB);
  localparam int unsigned DIV_W = $clog2(CPU_DIV);

  link_state_e       state_q;
  link_state_e       mode_st;
  logic              mode_change;
  logic [IDX_W-1:0]  idx_q;
  logic [DIV_W-1:0]  div_q;
  logic [ADDR_W-1:0] load_addr_q;
  logic [WORD_W-1:0] asm_q;
  logic [WORD_W-1:0] asm_next;
  logic              ser_en;

  assign mode_st     = link_state_e'(mode);
  assign mode_change = (mode_st != state_q);
  // The serializer runs only while DUMP is current and not being left this edge.
  assign ser_en      = (state_q == StDump) && !mode_change;
  assign busy        = (idx_q != '0);

  // Assembly register with the incoming byte merged into the current lane.
  always_comb begin
    asm_next = asm_q;
    asm_next[int'(idx_q) * 8 +: 8] = in_byte;
  end

  // Mode-following FSM with load assembly, write strobe and CPU step divider.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      div_q       <= '0;
      load_addr_q <= '0;
      asm_q       <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_step    <= 1'b0;
    end else begin
      state_q  <= mode_st;
      mem_we   <= 1'b0;
      cpu_step <= 1'b0;
      if (mode_change) begin
        // A partial word is dropped simply by rewinding the byte index.
        idx_q <= '0;
        div_q <= '0;
        if (mode_st == StLoad) begin
          load_addr_q <= '0;
        end
      end else begin
        case (state_q)
          StLoad: begin
            if (in_valid) begin
              asm_q <= asm_next;
              if (idx_q == IDX_W'(NB - 1)) begin
                idx_q       <= '0;
                mem_we      <= 1'b1;
                mem_addr    <= load_addr_q;
                mem_wdata   <= asm_next;
                // Internal address advances now; mem_addr keeps the written one.
                load_addr_q <= load_addr_q + ADDR_W'(1);
              end else begin
                idx_q <= idx_q + IDX_W'(1);
              end
            end
          end
          StRun: begin
            if (div_q == DIV_W'(CPU_DIV - 1)) begin
              div_q <= '0;
            end else begin
              div_q <= div_q + DIV_W'(1);
            end
            // Registered pulse lands on every CPU_DIV-th RUN cycle.
            cpu_step <= (div_q == DIV_W'(CPU_DIV - 2));
          end
          default: ;
        endcase
      end
    end
  end

  byte_serializer #(
    .WORD_W (WORD_W)
  ) u_serializer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (ser_en),
    .dbg_word  (dbg_word),
    .out_byte  (out_byte),
    .out_valid (out_valid)
  );

endmodule

// File: tb/tb_byte_link_bridge.sv
// Bench for byte_link_bridge: directed scenarios with literal expectations plus
// a randomized run checked every cycle against a transaction-level model.
module tb_byte_link_bridge;

  localparam int WORD_W  = 32;
  localparam int ADDR_W  = 2;
  localparam int CPU_DIV = 4;
  localparam int NB      = WORD_W / 8;

  localparam logic [1:0] M_IDLE = 2'b00;
  localparam logic [1:0] M_LOAD = 2'b01;
  localparam logic [1:0] M_RUN  = 2'b10;
  localparam logic [1:0] M_DUMP = 2'b11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic [7:0]        in_byte = 8'h00;
  logic              in_valid = 1'b0;
  logic [WORD_W-1:0] dbg_word = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              cpu_step;
  logic [7:0]        out_byte;
  logic              out_valid;
  logic              busy;

  int checks = 0;
  int errors = 0;

  byte_link_bridge #(
    .WORD_W  (WORD_W),
    .ADDR_W  (ADDR_W),
    .CPU_DIV (CPU_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_step  (cpu_step),
    .dbg_word  (dbg_word),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: what the outputs must be during the cycle after each edge.
  logic [1:0]        m_state = 2'b00;
  logic [7:0]        m_bytes[$];
  int                m_addr = 0;
  int                m_run = 0;
  int                m_dump = 0;
  logic [WORD_W-1:0] m_snap = '0;
  logic              e_we = 1'b0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [WORD_W-1:0] e_wdata = '0;
  logic              e_step = 1'b0;
  logic [7:0]        e_ob = 8'h00;
  logic              e_ov = 1'b0;
  bit                m_live = 1'b0;

  always @(posedge clk) begin
    logic [WORD_W-1:0] w;
    if (!rst_n) begin
      m_live  = 1'b1;
      m_state = M_IDLE;
      m_bytes.delete();
      m_addr  = 0;
      m_run   = 0;
      m_dump  = 0;
      m_snap  = '0;
      e_we    = 1'b0;
      e_addr  = '0;
      e_wdata = '0;
      e_step  = 1'b0;
      e_ob    = 8'h00;
      e_ov    = 1'b0;
    end else if (m_live) begin
      e_we   = 1'b0;
      e_step = 1'b0;
      e_ov   = 1'b0;
      e_ob   = 8'h00;
      if (mode != m_state) begin
        m_bytes.delete();
        if (mode == M_LOAD) m_addr = 0;
        m_state = mode;
        m_run   = 0;
        m_dump  = 0;
      end else begin
        case (m_state)
          M_LOAD: begin
            if (in_valid) begin
              m_bytes.push_back(in_byte);
              if (m_bytes.size() == NB) begin
                w = '0;
                for (int i = 0; i < NB; i++) w[8*i +: 8] = m_bytes[i];
                e_we    = 1'b1;
                e_addr  = m_addr[ADDR_W-1:0];
                e_wdata = w;
                m_addr  = (m_addr + 1) % (1 << ADDR_W);
                m_bytes.delete();
              end
            end
          end
          M_RUN: begin
            m_run++;
            e_step = ((m_run + 1) % CPU_DIV == 0);
          end
          M_DUMP: begin
            m_dump++;
            if ((m_dump - 1) % NB == 0) m_snap = dbg_word;
            e_ov = 1'b1;
            e_ob = m_snap[8*((m_dump - 1) % NB) +: 8];
          end
          default: ;
        endcase
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("mem_we", 64'(mem_we), 64'(e_we));
      chk("mem_addr", 64'(mem_addr), 64'(e_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
      chk("cpu_step", 64'(cpu_step), 64'(e_step));
      chk("out_valid", 64'(out_valid), 64'(e_ov));
      chk("out_byte", 64'(out_byte), 64'(e_ob));
      chk("busy", 64'(busy), 64'(m_bytes.size() != 0));
    end
  end

  // Write log used by the directed scenarios.
  logic [ADDR_W-1:0] wr_a[$];
  logic [WORD_W-1:0] wr_d[$];
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_a.push_back(mem_addr);
      wr_d.push_back(mem_wdata);
    end
  end

  task automatic drive(input logic [1:0] m, input logic v, input logic [7:0] b);
    mode     = m;
    in_valid = v;
    in_byte  = b;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, 64'(mem_we), 64'h0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'h0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'h0);
    chk({tag, "_step"}, 64'(cpu_step), 64'h0);
    chk({tag, "_ov"}, 64'(out_valid), 64'h0);
    chk({tag, "_ob"}, 64'(out_byte), 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
  endtask

  logic [7:0]        dump_exp[4] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
  logic [ADDR_W-1:0] wrap_exp[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Single word then a second word at the next address.
    drive(M_LOAD, 1'b0, 8'h00);
    wr_a.delete(); wr_d.delete();
    drive(M_LOAD, 1'b1, 8'h13);
    chk("load_busy", 64'(busy), 64'h1);
    drive(M_LOAD, 1'b1, 8'h05);
    drive(M_LOAD, 1'b1, 8'h10);
    drive(M_LOAD, 1'b1, 8'h00);
    chk("w0_we", 64'(mem_we), 64'h1);
    chk("w0_addr", 64'(mem_addr), 64'h0);
    chk("w0_data", 64'(mem_wdata), 64'h00100513);
    drive(M_LOAD, 1'b1, 8'h11);
    chk("w0_we_one_cycle", 64'(mem_we), 64'h0);
    drive(M_LOAD, 1'b1, 8'h22);
    drive(M_LOAD, 1'b1, 8'h33);
    drive(M_LOAD, 1'b1, 8'h44);
    drive(M_LOAD, 1'b0, 8'h00);
    drive(M_LOAD, 1'b0, 8'h00);
    chk("w1_count", 64'(wr_a.size()), 64'd2);
    if (wr_a.size() == 2) begin
      chk("w1_addr", 64'(wr_a[1]), 64'h1);
      chk("w1_data", 64'(wr_d[1]), 64'h44332211);
    end

    // Partial word discarded by a mode excursion.
    drive(M_IDLE, 1'b0, 8'h00);
    drive(M_LOAD, 1'b0, 8'h00);
    wr_a.delete(); wr_d.delete();
    drive(M_LOAD, 1'b1, 8'h01);
    drive(M_LOAD, 1'b1, 8'h02);
    drive(M_RUN, 1'b0, 8'h00);
    drive(M_RUN, 1'b0, 8'h00);
    drive(M_LOAD, 1'b0, 8'h00);
    drive(M_LOAD, 1'b1, 8'hAA);
    drive(M_LOAD, 1'b1, 8'hBB);
    drive(M_LOAD, 1'b1, 8'hCC);
    drive(M_LOAD, 1'b1, 8'hDD);
    drive(M_LOAD, 1'b0, 8'h00);
    drive(M_LOAD, 1'b0, 8'h00);
    chk("discard_count", 64'(wr_a.size()), 64'd1);
    if (wr_a.size() == 1) begin
      chk("discard_addr", 64'(wr_a[0]), 64'h0);
      chk("discard_data", 64'(wr_d[0]), 64'hDDCCBBAA);
    end

    // Address wrap with a 2-bit address.
    drive(M_IDLE, 1'b0, 8'h00);
    drive(M_LOAD, 1'b0, 8'h00);
    wr_a.delete(); wr_d.delete();
    for (int i = 0; i < 5 * NB; i++) drive(M_LOAD, 1'b1, 8'($urandom));
    drive(M_LOAD, 1'b0, 8'h00);
    drive(M_LOAD, 1'b0, 8'h00);
    chk("wrap_count", 64'(wr_a.size()), 64'd5);
    if (wr_a.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("wrap_addr", 64'(wr_a[i]), 64'(wrap_exp[i]));
    end

    // RUN pacing.
    drive(M_IDLE, 1'b0, 8'h00);
    mode = M_RUN;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("run_step", 64'(cpu_step), 64'(i % 4 == 0));
    end
    mode = M_IDLE;
    @(negedge clk);
    chk("run_exit_step", 64'(cpu_step), 64'h0);

    // DUMP serialization.
    dbg_word = 32'hCAFEF00D;
    mode = M_DUMP;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("dump_first_ov", 64'(out_valid), 64'h0);
      end else begin
        chk("dump_ov", 64'(out_valid), 64'h1);
        chk("dump_byte", 64'(out_byte), 64'(dump_exp[(i - 2) % 4]));
      end
    end
    mode = M_IDLE;
    @(negedge clk);
    chk("dump_exit_ov", 64'(out_valid), 64'h0);
    chk("dump_exit_ob", 64'(out_byte), 64'h0);

    // Reset in the middle of a word.
    drive(M_LOAD, 1'b0, 8'h00);
    for (int i = 0; i < NB; i++) drive(M_LOAD, 1'b1, 8'(8'h50 + i));
    drive(M_LOAD, 1'b1, 8'h61);
    drive(M_LOAD, 1'b1, 8'h62);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_byte  = 8'h63;
    @(negedge clk);
    chk_all_zero("midreset");
    rst_n = 1'b1;
    drive(M_LOAD, 1'b0, 8'h00);
    wr_a.delete(); wr_d.delete();
    for (int i = 0; i < NB; i++) drive(M_LOAD, 1'b1, 8'(8'h70 + i));
    drive(M_LOAD, 1'b0, 8'h00);
    drive(M_LOAD, 1'b0, 8'h00);
    chk("postreset_count", 64'(wr_a.size()), 64'd1);
    if (wr_a.size() == 1) begin
      chk("postreset_addr", 64'(wr_a[0]), 64'h0);
      chk("postreset_data", 64'(wr_d[0]), 64'h73727170);
    end

    // Randomized traffic; bytes are never offered on a mode-change edge.
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 29) == 0) begin
        mode = ($urandom_range(0, 2) == 0) ? M_LOAD : 2'($urandom_range(0, 3));
      end
      in_valid = ($urandom_range(0, 3) != 0) && rst_n && (mode == m_state);
      in_byte  = 8'($urandom);
      dbg_word = WORD_W'($urandom);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
